sram_arbiter: RTL and testbench

Two-port arbiter and access sequencer for the board's external asynchronous 512K×16 static RAM. It sits between up to two on-chip requesters (for example a pattern writer and a readback/LED host) and the `sram` core's flat word interface: address, write data, read data and write-enable. It serialises requests with round-robin fairness, generates the setup, write-pulse and hold timing the async RAM needs, and returns read data to the requester that owns the access.

---
 rtl/sram_arb_pkg.sv | 17 +
 rtl/rr_arb2.sv | 16 +
 rtl/sram_arbiter.sv | 114 +++++++++++
 tb/tb_sram_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared definitions for the external SRAM arbiter: FSM state encoding,
// default bus widths and the number of requesting ports.
package sram_arb_pkg;

    localparam int DEF_AW    = 19;
    localparam int DEF_DW    = 16;
    localparam int NUM_PORTS = 2;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_SETUP = 3'd1;
    localparam state_t ST_WRITE = 3'd2;
    localparam state_t ST_HOLD  = 3'd3;
    localparam state_t ST_READ  = 3'd4;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone request always wins, a tie goes to the
// port that was not granted last. Output is one-hot (or zero when idle).
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Serialises two requesters onto the async 512Kx16 SRAM core, generating
// setup / write-pulse / hold timing and returning read data to the owner.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int AW       = DEF_AW,
    parameter int DW       = DEF_DW,
    parameter int WR_PULSE = 2,
    parameter int RD_WAIT  = 2
) (
    input  logic                 CLOCK_50,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] req,
    input  logic [NUM_PORTS-1:0] we,
    input  logic [AW-1:0]        addr0,
    input  logic [AW-1:0]        addr1,
    input  logic [DW-1:0]        wdata0,
    input  logic [DW-1:0]        wdata1,
    output logic [NUM_PORTS-1:0] gnt,
    output logic [NUM_PORTS-1:0] rvalid,
    output logic [DW-1:0]        rdata,
    output logic                 busy,
    output logic [AW-1:0]        sram_addr,
    output logic [DW-1:0]        sram_wdata,
    input  logic [DW-1:0]        sram_rdata,
    output logic                 sram_we
);

    localparam int MAX_WAIT = (WR_PULSE > RD_WAIT) ? WR_PULSE : RD_WAIT;
    localparam int CW       = $clog2(MAX_WAIT + 1);

    state_t               state;
    logic [CW-1:0]        cnt;
    logic                 we_q;
    logic                 owner;
    logic                 last;
    logic [NUM_PORTS-1:0] pick;
    logic                 win;

    rr_arb2 u_arb (
        .req   (req),
        .last  (last),
        .grant (pick)
    );

    assign win  = pick[1];
    assign busy = (state != ST_IDLE);

    // sram_we is a register so it only rises one full setup cycle after the
    // address was latched and falls one hold cycle before it may change again.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            we_q       <= 1'b0;
            owner      <= 1'b0;
            last       <= 1'b1;
            gnt        <= '0;
            rvalid     <= '0;
            rdata      <= '0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            sram_we    <= 1'b0;
        end else begin
            gnt    <= '0;
            rvalid <= '0;
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        owner     <= win;
                        last      <= win;
                        we_q      <= we[win];
                        gnt       <= pick;
                        sram_addr <= win ? addr1 : addr0;
                        if (we[win]) begin
                            sram_wdata <= win ? wdata1 : wdata0;
                        end
                        state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    cnt     <= '0;
                    sram_we <= we_q;
                    state   <= we_q ? ST_WRITE : ST_READ;
                end
                ST_WRITE: begin
                    if (cnt == CW'(WR_PULSE - 1)) begin
                        sram_we <= 1'b0;
                        state   <= ST_HOLD;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_HOLD: begin
                    state <= ST_IDLE;
                end
                ST_READ: begin
                    if (cnt == CW'(RD_WAIT - 1)) begin
                        rdata         <= sram_rdata;
                        rvalid[owner] <= 1'b1;
                        state         <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    sram_we <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomised scoreboard bench for sram_arbiter: stimulus predicts grant order
// and read data from a reference memory; a monitor checks every cycle.
module tb_sram_arbiter;

    localparam int AW       = 19;
    localparam int DW       = 16;
    localparam int WR_PULSE = 2;
    localparam int RD_WAIT  = 2;

    logic          CLOCK_50;
    logic          rst_n;
    logic [1:0]    req;
    logic [1:0]    we;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic [1:0]    gnt;
    logic [1:0]    rvalid;
    logic [DW-1:0] rdata;
    logic          busy;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata;
    logic          sram_we;

    sram_arbiter #(
        .AW(AW), .DW(DW), .WR_PULSE(WR_PULSE), .RD_WAIT(RD_WAIT)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .rst_n      (rst_n),
        .req        (req),
        .we         (we),
        .addr0      (addr0),
        .addr1      (addr1),
        .wdata0     (wdata0),
        .wdata1     (wdata1),
        .gnt        (gnt),
        .rvalid     (rvalid),
        .rdata      (rdata),
        .busy       (busy),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .sram_we    (sram_we)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    // Behavioural async SRAM
    logic [DW-1:0] sram_mem [0:(1<<AW)-1];
    initial begin
        for (int i = 0; i < (1 << AW); i++) sram_mem[i] = '0;
    end
    always @(posedge CLOCK_50) begin
        if (sram_we) sram_mem[sram_addr] <= sram_wdata;
    end
    assign sram_rdata = sram_mem[sram_addr];

    typedef struct {
        int            port;
        bit            is_wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rexp;
    } txn_t;

    txn_t          exp_q[$];
    logic [DW-1:0] ref_mem [int];
    int            model_last = 1;
    int            checks = 0;
    int            errors = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the expected transaction on each grant, then checks the
    // timing of sram_we, busy, rvalid and the stability of address/data.
    txn_t       cur;
    bit         active = 0;
    int         since  = 0;
    logic       exp_we;
    logic       exp_busy;
    logic [1:0] exp_rv;

    always @(negedge CLOCK_50) begin
        if (!rst_n) begin
            checkOutput("reset_outputs",
                        {gnt, rvalid, busy, sram_we, rdata, sram_addr, sram_wdata}, 64'h0);
            active = 0;
        end else begin
            if (gnt != 2'b00) begin
                if (exp_q.size() == 0) begin
                    checkOutput("gnt_unexpected", {62'h0, gnt}, 64'h0);
                end else begin
                    cur    = exp_q.pop_front();
                    active = 1;
                    since  = 0;
                    checkOutput("gnt_port", {62'h0, gnt}, {62'h0, 2'(1 << cur.port)});
                end
            end else if (active) begin
                since++;
            end
            if (active) begin
                exp_we   = cur.is_wr && since >= 1 && since <= WR_PULSE;
                exp_busy = since <= (cur.is_wr ? 1 + WR_PULSE : RD_WAIT);
                exp_rv   = (!cur.is_wr && since == 1 + RD_WAIT) ? 2'(1 << cur.port) : 2'b00;
                checkOutput("sram_we_timing", {63'h0, sram_we}, {63'h0, exp_we});
                checkOutput("busy_timing", {63'h0, busy}, {63'h0, exp_busy});
                checkOutput("rvalid_timing", {62'h0, rvalid}, {62'h0, exp_rv});
                checkOutput("sram_addr_held", {45'h0, sram_addr}, {45'h0, cur.addr});
                if (cur.is_wr)
                    checkOutput("sram_wdata_held", {48'h0, sram_wdata}, {48'h0, cur.wdata});
                if (exp_rv != 2'b00)
                    checkOutput("rdata", {48'h0, rdata}, {48'h0, cur.rexp});
            end else begin
                checkOutput("idle_outputs", {60'h0, busy, sram_we, rvalid}, 64'h0);
            end
        end
    end

    // One round: the requested ports are raised together, the reference model
    // predicts grant order and read data, and the round ends when all done.
    task automatic applyStimulus(input logic [1:0] ports, input logic [1:0] wes,
                                 input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                 input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        int   order[$];
        txn_t t;
        int   n;
        if (ports == 2'b11) begin
            order.push_back(model_last == 0 ? 1 : 0);
            order.push_back(model_last);
        end else begin
            order.push_back(ports[1] ? 1 : 0);
        end
        foreach (order[i]) begin
            t.port  = order[i];
            t.is_wr = wes[t.port];
            t.addr  = (t.port == 1) ? a1 : a0;
            t.wdata = (t.port == 1) ? d1 : d0;
            t.rexp  = ref_mem.exists(int'(t.addr)) ? ref_mem[int'(t.addr)] : '0;
            if (t.is_wr) ref_mem[int'(t.addr)] = t.wdata;
            exp_q.push_back(t);
            model_last = t.port;
        end
        we     = wes;
        addr0  = a0;
        addr1  = a1;
        wdata0 = d0;
        wdata1 = d1;
        req    = ports;
        n      = 0;
        while ((req != 2'b00 || busy) && n < 60) begin
            @(negedge CLOCK_50);
            n++;
            req = req & ~gnt;
        end
        @(negedge CLOCK_50);
        if (n >= 60) begin
            checks++;
            errors++;
            $display("[TB] FAIL round_timeout actual=%0d cycles required<60", n);
            req = 2'b00;
            exp_q.delete();
        end
        checkOutput("queue_drained", 64'(exp_q.size()), 64'h0);
    endtask

    task automatic resetDuringWrite();
        txn_t t;
        int   n;
        t.port  = 0;
        t.is_wr = 1;
        t.addr  = 19'h33333;
        t.wdata = 16'hDEAD;
        t.rexp  = '0;
        exp_q.push_back(t);
        model_last = 0;
        we     = 2'b01;
        addr0  = t.addr;
        wdata0 = t.wdata;
        req    = 2'b01;
        n      = 0;
        while (req != 2'b00 && n < 20) begin
            @(negedge CLOCK_50);
            n++;
            req = req & ~gnt;
        end
        req = 2'b00;
        @(posedge CLOCK_50);
        #2;
        checkOutput("write_active_before_reset", {63'h0, sram_we}, 64'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("reset_async_we", {63'h0, sram_we}, 64'h0);
        checkOutput("reset_async_flags", {59'h0, gnt, rvalid, busy}, 64'h0);
        repeat (3) @(negedge CLOCK_50);
        rst_n      = 1'b1;
        model_last = 1;
        exp_q.delete();
        repeat (4) @(negedge CLOCK_50);
    endtask

    initial begin
        rst_n  = 1'b0;
        req    = 2'b00;
        we     = 2'b00;
        addr0  = '0;
        addr1  = '0;
        wdata0 = '0;
        wdata1 = '0;
        repeat (3) @(negedge CLOCK_50);
        rst_n = 1'b1;
        @(negedge CLOCK_50);

        applyStimulus(2'b01, 2'b01, 19'h00005, 19'h0, 16'h1234, 16'h0);
        applyStimulus(2'b10, 2'b00, 19'h0, 19'h00005, 16'h0, 16'h0);

        for (int i = 0; i < 4; i++)
            applyStimulus(2'b11, 2'b00, 19'($urandom_range(0, 7)), 19'($urandom_range(0, 7)),
                          16'h0, 16'h0);

        applyStimulus(2'b01, 2'b01, 19'h7FFFF, 19'h0, 16'hBEEF, 16'h0);
        applyStimulus(2'b01, 2'b01, 19'h00000, 19'h0, 16'hCAFE, 16'h0);
        applyStimulus(2'b11, 2'b00, 19'h7FFFF, 19'h00000, 16'h0, 16'h0);

        resetDuringWrite();

        applyStimulus(2'b11, 2'b00, 19'h00005, 19'h00005, 16'h0, 16'h0);

        for (int i = 0; i < 24; i++)
            applyStimulus(2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)),
                          19'($urandom_range(0, 7)), 19'($urandom_range(0, 7)),
                          16'($urandom), 16'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
